// File: rtl/tdc_evdma.sv
// tdc_evdma -- event-driven DMA sequencer for TDC readout.
//
// On every rising edge of the TDC interrupt (evt_i) the block reads COUNT
// words from the TDC Wishbone slave (starting at SRC) and stores them in a
// ring buffer in SRAM (base DST, 2**ring_aw words). Software drains the ring
// through RDPTR; irq stays high while the ring holds data and the block is
// enabled.
//
// Optional feature (macro TDC_EVDMA_TIMESTAMP_EN): a free-running sys_clk
// counter is sampled at the event edge and written as the first ring word of
// every record, ahead of the COUNT data words.
//
// Ports
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   csr_a/we/di/do       CSR bus; page csr_a[13:10], register csr_a[2:0],
//                        registered read data (0 when page not selected)
//   evt_i                TDC interrupt level input
//   irq                  ring-not-empty interrupt
//   wb_*                 Wishbone classic master (conbus master 2)
//
// CSR map
//   0 CTRL   b0 enable, b1 clear (write-1; reads back as clear pending)
//   1 SRC    source base (word aligned)
//   2 COUNT  [3:0] words per event
//   3 DST    ring base (word aligned)
//   4 WRPTR  read-only next write index
//   5 RDPTR  software read index
//   6 STAT   b0 busy, b1 overflow (W1C), b2 lost (W1C), [31:16] event count
//
// FSM states
//   state | meaning
//   IDLE  | waiting for a pending event (or applying a deferred clear)
//   CHK   | ring space check for one record
//   RD    | Wishbone read of SRC+4*i
//   GAP   | one idle bus cycle between a read and the following write
//   WR    | Wishbone write of DST+4*wrptr (timestamp or data word)
module tdc_evdma #(
  parameter logic [3:0] csr_addr = 4'h2,
  parameter int         ring_aw  = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        evt_i,
  output logic        irq,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {S_IDLE, S_CHK, S_RD, S_GAP, S_WR} state_t;

  state_t             state, state_next;
  logic               enable, clear_pend;
  logic [31:0]        src, dst, dat_q;
  logic [3:0]         count, cnt_q, idx;
  logic [ring_aw-1:0] wrptr, rdptr, used, free;
  logic               overflow, lost, evt_q, pend;
  logic [15:0]        evt_cnt;
  logic               page_sel, csr_wr, clear_wr, edge_det, clear_now;
  logic               no_room, busy, last_word;
  logic [2:0]         reg_sel;
  logic [4:0]         rec_len, idx_inc;
  logic               unused_csr_a;
`ifdef TDC_EVDMA_TIMESTAMP_EN
  logic [31:0]        ts_cnt, ts_q;
  logic               wr_ts;
`endif

  assign page_sel     = (csr_a[13:10] == csr_addr);
  assign reg_sel      = csr_a[2:0];
  assign unused_csr_a = ^csr_a[9:3];
  assign csr_wr       = page_sel & csr_we;
  assign clear_wr     = csr_wr & (reg_sel == 3'd0) & csr_di[1];
  assign edge_det     = evt_i & ~evt_q;
  assign busy         = (state != S_IDLE) | pend;
  // A clear requested while busy waits here until the FSM is back in IDLE.
  assign clear_now    = (state == S_IDLE) & (clear_pend | clear_wr);

  // Free slots = depth-1-used, which is the bitwise inverse of used.
  assign used    = wrptr - rdptr;
  assign free    = ~used;
`ifdef TDC_EVDMA_TIMESTAMP_EN
  assign rec_len = {1'b0, count} + 5'd1;
`else
  assign rec_len = {1'b0, count};
`endif
  assign no_room = 32'(free) < 32'(rec_len);

  assign idx_inc = {1'b0, idx} + 5'd1;
`ifdef TDC_EVDMA_TIMESTAMP_EN
  assign last_word = wr_ts ? (cnt_q == 4'd0) : (idx_inc >= {1'b0, cnt_q});
`else
  assign last_word = (idx_inc >= {1'b0, cnt_q});
`endif

  assign wb_stb_o = wb_cyc_o;
  assign wb_sel_o = 4'hf;
  assign wb_cti_o = 3'b000;
  assign wb_dat_o = dat_q;
  assign irq      = (wrptr != rdptr) & enable;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    wb_cyc_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_adr_o   = 32'h0;
    case (state)
      S_IDLE: begin
        if (!clear_now && pend) state_next = S_CHK;
      end
      S_CHK: begin
        if (no_room) begin
          state_next = S_IDLE;
        end else begin
`ifdef TDC_EVDMA_TIMESTAMP_EN
          state_next = S_WR;
`else
          state_next = (count == 4'd0) ? S_IDLE : S_RD;
`endif
        end
      end
      S_RD: begin
        wb_cyc_o = 1'b1;
        wb_adr_o = src + {26'd0, idx, 2'b00};
        if (wb_ack_i) state_next = S_GAP;
      end
      S_GAP: begin
        state_next = S_WR;
      end
      S_WR: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = dst + (32'(wrptr) << 2);
        if (wb_ack_i) state_next = last_word ? S_IDLE : S_RD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      enable     <= 1'b0;
      clear_pend <= 1'b0;
      src        <= 32'h0;
      dst        <= 32'h0;
      count      <= 4'h0;
      cnt_q      <= 4'h0;
      idx        <= 4'h0;
      wrptr      <= '0;
      rdptr      <= '0;
      overflow   <= 1'b0;
      lost       <= 1'b0;
      evt_q      <= 1'b0;
      pend       <= 1'b0;
      evt_cnt    <= 16'h0;
      dat_q      <= 32'h0;
      csr_do     <= 32'h0;
`ifdef TDC_EVDMA_TIMESTAMP_EN
      ts_cnt     <= 32'h0;
      ts_q       <= 32'h0;
      wr_ts      <= 1'b0;
`endif
    end else begin
      evt_q <= evt_i;
`ifdef TDC_EVDMA_TIMESTAMP_EN
      ts_cnt <= ts_cnt + 32'd1;
`endif

      if (csr_wr) begin
        case (reg_sel)
          3'd0: enable <= csr_di[0];
          3'd1: src    <= {csr_di[31:2], 2'b00};
          3'd2: count  <= csr_di[3:0];
          3'd3: dst    <= {csr_di[31:2], 2'b00};
          3'd5: rdptr  <= csr_di[ring_aw-1:0];
          3'd6: begin
            if (csr_di[1]) overflow <= 1'b0;
            if (csr_di[2]) lost     <= 1'b0;
          end
          default: ;
        endcase
      end

      if (clear_now)     clear_pend <= 1'b0;
      else if (clear_wr) clear_pend <= 1'b1;

      if (state == S_IDLE && state_next == S_CHK) begin
        pend    <= 1'b0;
        evt_cnt <= evt_cnt + 16'd1;
      end

      // pend is only ever set while clear, so the edge never overrides the
      // consume above; an edge seen while pend is still set is lost.
      if (edge_det && enable) begin
        if (pend) begin
          lost <= 1'b1;
        end else begin
          pend <= 1'b1;
`ifdef TDC_EVDMA_TIMESTAMP_EN
          ts_q <= ts_cnt;
`endif
        end
      end

      case (state)
        S_CHK: begin
          cnt_q <= count;
          idx   <= 4'h0;
          if (no_room) overflow <= 1'b1;
`ifdef TDC_EVDMA_TIMESTAMP_EN
          wr_ts <= 1'b1;
          dat_q <= ts_q;
`endif
        end
        S_RD: begin
          if (wb_ack_i) dat_q <= wb_dat_i;
        end
        S_WR: begin
          if (wb_ack_i) begin
            wrptr <= wrptr + 1'b1;
`ifdef TDC_EVDMA_TIMESTAMP_EN
            if (wr_ts) wr_ts <= 1'b0;
            else       idx   <= idx_inc[3:0];
`else
            idx <= idx_inc[3:0];
`endif
          end
        end
        default: ;
      endcase

      if (clear_now) begin
        wrptr    <= '0;
        rdptr    <= '0;
        overflow <= 1'b0;
        lost     <= 1'b0;
        evt_cnt  <= 16'h0;
      end

      if (page_sel) begin
        case (reg_sel)
          3'd0:    csr_do <= {30'd0, clear_pend, enable};
          3'd1:    csr_do <= src;
          3'd2:    csr_do <= {28'd0, count};
          3'd3:    csr_do <= dst;
          3'd4:    csr_do <= 32'(wrptr);
          3'd5:    csr_do <= 32'(rdptr);
          3'd6:    csr_do <= {evt_cnt, 13'd0, lost, overflow, busy};
          default: csr_do <= 32'h0;
        endcase
      end else begin
        csr_do <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_tdc_evdma.sv
module tb_tdc_evdma;
  localparam logic [3:0] PAGE = 4'h2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        evt_i;
  logic        irq;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  tdc_evdma #(.csr_addr(4'h2), .ring_aw(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .evt_i(evt_i), .irq(irq),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  // Wishbone slave model with programmable ack latency and transfer log.
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] wr_adr[128];
  logic [31:0] wr_dat[128];
  logic [31:0] rd_adr[128];
  int          n_wr = 0;
  int          n_rd = 0;
  logic [31:0] tb_cyc = 32'h0;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  always @(posedge sys_clk) begin
    tb_cyc <= sys_rst ? 32'h0 : tb_cyc + 32'd1;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      if (wb_we_o) begin
        if (n_wr < 128) begin
          wr_adr[n_wr] <= wb_adr_o;
          wr_dat[n_wr] <= wb_dat_o;
        end
        n_wr <= n_wr + 1;
      end else begin
        if (n_rd < 128) rd_adr[n_rd] <= wb_adr_o;
        n_rd <= n_rd + 1;
      end
    end
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (wait_cnt >= ack_delay) begin
        wb_ack_i <= 1'b1;
        wb_dat_i <= wb_we_o ? 32'h0 : rd_pat(wb_adr_o);
        wait_cnt <= 0;
      end else begin
        wb_ack_i <= 1'b0;
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wb_ack_i <= 1'b0;
      wait_cnt <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] r, input logic [31:0] d);
    csr_a  = {PAGE, 7'd0, r};
    csr_di = d;
    csr_we = 1'b1;
    @(posedge sys_clk);
    #1;
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] r, output logic [31:0] d);
    csr_a  = {PAGE, 7'd0, r};
    csr_we = 1'b0;
    @(posedge sys_clk);
    #1;
    d = csr_do;
  endtask

  task automatic pulse();
    evt_i = 1'b1;
    tick(1);
    evt_i = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    bit done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      csr_rd(3'd6, d);
      if (d[0] == 1'b0) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle: busy still 1 after 600 polls, required 0", name);
    end
  endtask

  task automatic wait_cyc(input string name);
    bit seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (wb_cyc_o) seen = 1;
      else tick(1);
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_cyc: cyc never rose within 50 cycles", name);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    sys_rst = 1'b1;
    tick(3);
    sys_rst = 1'b0;
    n_tests++;
    if ({irq, wb_cyc_o, wb_stb_o, wb_we_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_outputs: got irq/cyc/stb/we=%b required 0000", {irq, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    n_tests++;
    if ({wb_sel_o, wb_cti_o} !== 7'b1111_000) begin
      n_fail++;
      $display("FAIL rst_sel_cti: got %b required 1111000", {wb_sel_o, wb_cti_o});
    end
    n_tests++;
    if (csr_do !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_csr_do: got %h required 0", csr_do);
    end
    for (int r = 0; r < 7; r++) begin
      csr_rd(3'(r), d);
      n_tests++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_reg%0d: got %h required 0", r, d);
      end
    end
  endtask

  task automatic test_csr();
    logic [31:0] d;
    csr_wr(3'd1, 32'hA000_0003);
    csr_rd(3'd1, d);
    n_tests++;
    if (d !== 32'hA000_0000) begin
      n_fail++;
      $display("FAIL csr_src_align: got %h required a0000000", d);
    end
    csr_wr(3'd3, 32'h4000_0001);
    csr_rd(3'd3, d);
    n_tests++;
    if (d !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL csr_dst_align: got %h required 40000000", d);
    end
    csr_wr(3'd2, 32'hFFFF_FFF3);
    csr_rd(3'd2, d);
    n_tests++;
    if (d !== 32'h3) begin
      n_fail++;
      $display("FAIL csr_count_mask: got %h required 3", d);
    end
    csr_a  = {4'h3, 7'd0, 3'd1};
    csr_we = 1'b0;
    tick(1);
    n_tests++;
    if (csr_do !== 32'h0) begin
      n_fail++;
      $display("FAIL csr_other_page: got %h required 0", csr_do);
    end
    csr_wr(3'd5, 32'h5);
    csr_rd(3'd5, d);
    n_tests++;
    if (d !== 32'h5) begin
      n_fail++;
      $display("FAIL csr_rdptr: got %h required 5", d);
    end
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_disabled: got %b required 0", irq);
    end
    csr_wr(3'd0, 32'h1);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_enabled: got %b required 1", irq);
    end
    csr_wr(3'd5, 32'h0);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_empty: got %b required 0", irq);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int bw, br;
    csr_wr(3'd1, 32'hA000_0000);
    csr_wr(3'd2, 32'd3);
    csr_wr(3'd3, 32'h4000_0000);
    csr_wr(3'd0, 32'h3);
    bw = n_wr;
    br = n_rd;
    pulse();
    wait_idle("basic");
    n_tests++;
    if (n_rd - br != 3 || n_wr - bw != 3) begin
      n_fail++;
      $display("FAIL basic_count: got rd=%0d wr=%0d required 3/3", n_rd - br, n_wr - bw);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (rd_adr[br+k] !== 32'hA000_0000 + 32'(4*k)) begin
          n_fail++;
          $display("FAIL basic_rd_adr%0d: got %h required %h", k, rd_adr[br+k], 32'hA000_0000 + 32'(4*k));
        end
        n_tests++;
        if (wr_adr[bw+k] !== 32'h4000_0000 + 32'(4*k)) begin
          n_fail++;
          $display("FAIL basic_wr_adr%0d: got %h required %h", k, wr_adr[bw+k], 32'h4000_0000 + 32'(4*k));
        end
        n_tests++;
        if (wr_dat[bw+k] !== rd_pat(32'hA000_0000 + 32'(4*k))) begin
          n_fail++;
          $display("FAIL basic_wr_dat%0d: got %h required %h", k, wr_dat[bw+k], rd_pat(32'hA000_0000 + 32'(4*k)));
        end
      end
    end
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd3) begin
      n_fail++;
      $display("FAIL basic_wrptr: got %h required 3", d);
    end
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_irq: got %b required 1", irq);
    end
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0001_0000) begin
      n_fail++;
      $display("FAIL basic_stat: got %h required 00010000", d);
    end
  endtask

  task automatic test_count_zero();
    logic [31:0] d;
    int bw, br;
    csr_wr(3'd0, 32'h3);
    csr_wr(3'd2, 32'd0);
    bw = n_wr;
    br = n_rd;
    pulse();
    wait_idle("cnt0");
    n_tests++;
    if (n_wr != bw || n_rd != br) begin
      n_fail++;
      $display("FAIL cnt0_bus: got rd=%0d wr=%0d accesses required none", n_rd - br, n_wr - bw);
    end
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0001_0000) begin
      n_fail++;
      $display("FAIL cnt0_stat: got %h required 00010000", d);
    end
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL cnt0_wrptr: got %h required 0", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int bw, br;
    csr_wr(3'd0, 32'h3);
    csr_wr(3'd2, 32'd4);
    bw = n_wr;
    br = n_rd;
    repeat (4) begin
      pulse();
      wait_idle("ovf");
    end
    n_tests++;
    if (n_rd - br != 12 || n_wr - bw != 12) begin
      n_fail++;
      $display("FAIL ovf_bus: got rd=%0d wr=%0d required 12/12", n_rd - br, n_wr - bw);
    end
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd12) begin
      n_fail++;
      $display("FAIL ovf_wrptr: got %h required c", d);
    end
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0004_0002) begin
      n_fail++;
      $display("FAIL ovf_stat: got %h required 00040002", d);
    end
    csr_wr(3'd6, 32'h2);
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0004_0000) begin
      n_fail++;
      $display("FAIL ovf_w1c: got %h required 00040000", d);
    end
  endtask

  task automatic test_lost();
    logic [31:0] d;
    int br;
    csr_wr(3'd0, 32'h3);
    csr_wr(3'd2, 32'd3);
    ack_delay = 4;
    br = n_rd;
    pulse();
    pulse();
    pulse();
    wait_idle("lost");
    ack_delay = 0;
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0002_0004) begin
      n_fail++;
      $display("FAIL lost_stat: got %h required 00020004", d);
    end
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd6) begin
      n_fail++;
      $display("FAIL lost_wrptr: got %h required 6", d);
    end
    n_tests++;
    if (n_rd - br != 6) begin
      n_fail++;
      $display("FAIL lost_reads: got %0d required 6", n_rd - br);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [31:0] exp_adr[3];
    int bw;
    exp_adr[0] = 32'h4000_0038;
    exp_adr[1] = 32'h4000_003C;
    exp_adr[2] = 32'h4000_0000;
    csr_wr(3'd0, 32'h3);
    csr_wr(3'd2, 32'd7);
    pulse();
    wait_idle("wrap_a");
    pulse();
    wait_idle("wrap_b");
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd14) begin
      n_fail++;
      $display("FAIL wrap_pre_wrptr: got %h required e", d);
    end
    csr_wr(3'd5, 32'd10);
    csr_wr(3'd2, 32'd3);
    bw = n_wr;
    pulse();
    wait_idle("wrap_c");
    n_tests++;
    if (n_wr - bw != 3) begin
      n_fail++;
      $display("FAIL wrap_writes: got %0d required 3", n_wr - bw);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (wr_adr[bw+k] !== exp_adr[k]) begin
          n_fail++;
          $display("FAIL wrap_adr%0d: got %h required %h", k, wr_adr[bw+k], exp_adr[k]);
        end
      end
    end
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL wrap_wrptr: got %h required 1", d);
    end
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0003_0000) begin
      n_fail++;
      $display("FAIL wrap_stat: got %h required 00030000", d);
    end
  endtask

  task automatic test_stall_clear();
    logic [31:0] d;
    int drops;
    csr_wr(3'd0, 32'h3);
    csr_wr(3'd2, 32'd2);
    pulse();
    wait_idle("stall_a");
    csr_wr(3'd5, 32'd1);
    ack_delay = 20;
    pulse();
    wait_cyc("stall");
    csr_wr(3'd0, 32'h3);
    drops = 0;
    for (int k = 0; k < 12; k++) begin
      if (!(wb_cyc_o && wb_stb_o) || wb_we_o) drops++;
      tick(1);
    end
    n_tests++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL stall_stable: got %0d unstable cycles required 0", drops);
    end
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_wrptr_busy: got %h required 2", d);
    end
    csr_rd(3'd5, d);
    n_tests++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL stall_rdptr_busy: got %h required 1", d);
    end
    wait_idle("stall_b");
    ack_delay = 0;
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_wrptr_clr: got %h required 0", d);
    end
    csr_rd(3'd5, d);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_rdptr_clr: got %h required 0", d);
    end
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_stat_clr: got %h required 0", d);
    end
  endtask

  task automatic test_reset_midxfer();
    logic [31:0] d;
    int bw, br;
    csr_wr(3'd0, 32'h3);
    csr_wr(3'd2, 32'd2);
    ack_delay = 10;
    bw = n_wr;
    br = n_rd;
    pulse();
    wait_cyc("midrst");
    tick(2);
    sys_rst = 1'b1;
    tick(1);
    n_tests++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_drop: got cyc/stb=%b required 00", {wb_cyc_o, wb_stb_o});
    end
    sys_rst = 1'b0;
    tick(15);
    ack_delay = 0;
    n_tests++;
    if (n_wr != bw || n_rd != br || wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_bus: got rd=%0d wr=%0d cyc=%b required none", n_rd - br, n_wr - bw, wb_cyc_o);
    end
    csr_rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_stat: got %h required 0", d);
    end
  endtask

`ifdef TDC_EVDMA_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] d, exp_ts;
    int bw, br;
    csr_wr(3'd1, 32'hA000_0000);
    csr_wr(3'd3, 32'h4000_0000);
    csr_wr(3'd2, 32'd1);
    csr_wr(3'd0, 32'h3);
    bw = n_wr;
    br = n_rd;
    evt_i = 1'b1;
    exp_ts = tb_cyc;
    tick(1);
    evt_i = 1'b0;
    tick(1);
    wait_idle("ts");
    n_tests++;
    if (n_wr - bw != 2 || n_rd - br != 1) begin
      n_fail++;
      $display("FAIL ts_bus: got rd=%0d wr=%0d required 1/2", n_rd - br, n_wr - bw);
    end else begin
      n_tests++;
      if (wr_dat[bw] !== exp_ts || wr_adr[bw] !== 32'h4000_0000) begin
        n_fail++;
        $display("FAIL ts_word: got %h@%h required %h@40000000", wr_dat[bw], wr_adr[bw], exp_ts);
      end
      n_tests++;
      if (wr_dat[bw+1] !== rd_pat(32'hA000_0000) || wr_adr[bw+1] !== 32'h4000_0004) begin
        n_fail++;
        $display("FAIL ts_data: got %h@%h required %h@40000004", wr_dat[bw+1], wr_adr[bw+1], rd_pat(32'hA000_0000));
      end
    end
    csr_rd(3'd4, d);
    n_tests++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL ts_wrptr: got %h required 2", d);
    end
  endtask
`endif

  initial begin
    sys_rst = 1'b1;
    evt_i   = 1'b0;
    csr_a   = 14'h0;
    csr_we  = 1'b0;
    csr_di  = 32'h0;
    test_reset();
    test_csr();
`ifdef TDC_EVDMA_TIMESTAMP_EN
    test_timestamp();
`else
    test_basic();
    test_count_zero();
    test_overflow();
    test_lost();
    test_wrap();
    test_stall_clear();
    test_reset_midxfer();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
